// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a 1-cycle strobe per key.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 50000,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    // Parameter sanity: the synchroniser needs two cycles of each slot to settle.
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("keypad_scanner: SCAN_DIV>=4, DEBOUNCE_CNT>=2, REPEAT_*>=2 required");
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    logic [REP_W-1:0] rep_cnt;
    logic             rep_periodic;
`endif

    state_t            state;
    logic [3:0]        row_meta;
    logic [3:0]        row_s;
    logic [3:0]        row_lat;
    logic [1:0]        col_idx;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DEB_W-1:0]  deb_cnt;

    assign dbg_state = state;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic single_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta  <= 4'hF;
            row_s     <= 4'hF;
            row_lat   <= 4'hF;
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            slot_cnt  <= '0;
            deb_cnt   <= '0;
            key_value <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt      <= '0;
            rep_periodic <= 1'b0;
`endif
        end else begin
            row_meta  <= row_in;
            row_s     <= row_meta;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (row_s != 4'hF) begin
                            // Column stays frozen so the same key stays visible while debouncing.
                            row_lat <= row_s;
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_out <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (row_s != row_lat) begin
                        deb_cnt <= '0;
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                        col_out <= col_drive(col_idx + 2'd1);
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                        // Multi-low patterns (ghosting) are parked in HELD without a strobe.
                        if (single_low(row_lat)) begin
                            key_valid <= 1'b1;
                            key_value <= {low_index(row_lat), col_idx};
                            key_held  <= 1'b1;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (row_s == 4'hF) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt      <= '0;
                        rep_periodic <= 1'b0;
                    end else if (key_held) begin
                        if (rep_cnt == (rep_periodic ? PER_LAST : DLY_LAST)) begin
                            key_valid    <= 1'b1;
                            rep_cnt      <= '0;
                            rep_periodic <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
`endif
                    end
                end
                DEB_REL: begin
                    if (row_s != 4'hF) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        key_held <= 1'b0;
                        state    <= SCAN;
                        col_idx  <= col_idx + 2'd1;
                        col_out  <= col_drive(col_idx + 2'd1);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner: a keypad matrix model drives row_in from col_out,
// expected key codes go into a queue and a monitor checks every strobe against it.
module tb_keypad_scanner;

    localparam int SCAN_DIV      = 4;
    localparam int DEBOUNCE_CNT  = 8;
    localparam int REPEAT_DELAY  = 40;
    localparam int REPEAT_PERIOD = 16;
    // Press applied at the start of a column slot: wait out the slot, then debounce.
    localparam int PRESS_LAT     = SCAN_DIV + DEBOUNCE_CNT;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;
    logic [1:0] dbg_state;

    logic [15:0] keys;          // keys[row*4+col] = 1 when that key is pressed
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_v;
    logic [3:0]  exp_last;
    logic        prev_valid = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          strobe_count = 0;
    int unsigned cyc = 0;
    int unsigned last_strobe_cyc = 0;
    int unsigned n0;
    int          sc0;
    bit          rep_en;
    int          exp_offs[$];
    int          got_offs[$];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held (key_held),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / keypad matrix ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL strobe_back_to_back: key_valid high on two consecutive cycles at cycle %0d", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got key_value=%h at cycle %0d, expected no strobe", key_value, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if (key_value !== exp_v) begin
                    errors++;
                    $display("FAIL strobe_value: got key_value=%h, expected %h", key_value, exp_v);
                end
            end
            checks++;
            if (key_held !== 1'b1) begin
                errors++;
                $display("FAIL strobe_held: got key_held=%b with strobe, expected 1", key_held);
            end
            strobe_count++;
            last_strobe_cyc = cyc;
        end
        prev_valid = key_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic wait_col_start(input int c);
        logic [3:0] prev;
        bit found;
        prev  = col_out;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            tick();
            if (col_out == col_drive(c) && prev != col_drive(c)) found = 1;
            prev = col_out;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_resume: column %0d never became driven, col_out=%b", c, col_out);
        end
    endtask

    task automatic await_strobe(input string name, input int sc, input int unsigned t0, input int want_lat);
        int n;
        n = 0;
        while (strobe_count == sc && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (strobe_count == sc) begin
            errors++;
            $display("FAIL %s_timeout: no strobe within %0d cycles", name, n);
        end else if (int'(last_strobe_cyc - t0) != want_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, int'(last_strobe_cyc - t0), want_lat);
        end
    endtask

    task automatic press_single(input int k);
        wait_col_start(k % 4);
        exp_q.push_back(4'(k));
        sc0 = strobe_count;
        n0  = cyc;
        keys = 16'(1) << k;
        await_strobe("press", sc0, n0, PRESS_LAT);
        exp_last = 4'(k);
        tick();
        check("held_after_press", key_held, 1'b1);
    endtask

    task automatic release_and_check(input int c);
        int n;
        keys = '0;
        n = 0;
        while (key_held && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (key_held || n < DEBOUNCE_CNT + 1 || n > DEBOUNCE_CNT + 4) begin
            errors++;
            $display("FAIL release_time: key_held=%b after %0d cycles, expected 0 within %0d..%0d",
                     key_held, n, DEBOUNCE_CNT + 1, DEBOUNCE_CNT + 4);
        end
        check("release_next_col", col_out, col_drive((c + 1) % 4));
    endtask

    task automatic press_ghost(input int c, input int r1, input int r2);
        wait_col_start(c);
        sc0 = strobe_count;
        keys = (16'(1) << (r1 * 4 + c)) | (16'(1) << (r2 * 4 + c));
        repeat (PRESS_LAT + 10) tick();
        check("ghost_no_strobe", strobe_count - sc0, 0);
        check("ghost_not_held", key_held, 1'b0);
        check("ghost_value_kept", key_value, exp_last);
        keys = '0;
        repeat (2 * DEBOUNCE_CNT + 10) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif
        keys     = '0;
        exp_last = 4'h0;
        reset_n  = 1'b0;
        repeat (3) tick();
        check("reset_col_out", col_out, 4'b1110);
        check("reset_key_value", key_value, 4'h0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_held", key_held, 1'b0);

        // Idle scan: each column for SCAN_DIV cycles, 0->1->2->3->0.
        reset_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check("idle_col_seq", col_out, col_drive((k / SCAN_DIV) % 4));
        end

        // Key 6 (row1, col2).
        press_single(6);
        repeat (20) tick();
        release_and_check(2);

        // Bounce on key 0, ending in a stable press.
        wait_col_start(0);
        for (int i = 0; i < 10; i++) begin
            keys[0] = (i % 2 == 0);
            repeat (3) tick();
        end
        keys[0] = 1'b1;
        exp_q.push_back(4'h0);
        sc0 = strobe_count;
        n0  = cyc;
        for (int n = 0; n < 100 && strobe_count == sc0; n++) tick();
        checks++;
        if (strobe_count == sc0 || int'(last_strobe_cyc - n0) < DEBOUNCE_CNT + 2) begin
            errors++;
            $display("FAIL bounce_settle: strobes=%0d, delay %0d cycles, expected one strobe after >= %0d",
                     strobe_count - sc0, int'(last_strobe_cyc - n0), DEBOUNCE_CNT + 2);
        end
        exp_last = 4'h0;
        repeat (20) tick();
        check("bounce_single_strobe", strobe_count - sc0, 1);
        release_and_check(0);

        // Ghost: rows 0 and 3 on column 1.
        press_ghost(1, 0, 3);

        // Randomised mix of single presses and same-column double presses.
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                int k;
                k = $urandom_range(0, 15);
                press_single(k);
                repeat ($urandom_range(5, 30)) tick();
                release_and_check(k % 4);
            end else begin
                int c, r1, r2;
                c  = $urandom_range(0, 3);
                r1 = $urandom_range(0, 3);
                r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
                press_ghost(c, r1, r2);
            end
        end

        // Reset in the middle of a press debounce (key 4, row1 col0).
        wait_col_start(0);
        n0   = cyc;
        keys = 16'(1) << 4;
        repeat (SCAN_DIV + 5) tick();
        reset_n = 1'b0;
        #1;
        check("midreset_col_out", col_out, 4'b1110);
        check("midreset_key_value", key_value, 4'h0);
        check("midreset_key_valid", key_valid, 1'b0);
        check("midreset_key_held", key_held, 1'b0);
        tick();
        reset_n  = 1'b1;
        exp_last = 4'h0;
        exp_q.push_back(4'h4);
        sc0 = strobe_count;
        n0  = cyc;
        await_strobe("rerun_after_reset", sc0, n0, PRESS_LAT);
        exp_last = 4'h4;
        repeat (10) tick();
        release_and_check(0);

        // Key F held 100 cycles past its first strobe.
        exp_offs.delete();
        got_offs.delete();
        if (rep_en)
            for (int t = REPEAT_DELAY; t <= 100; t += REPEAT_PERIOD) begin
                exp_offs.push_back(t);
                exp_q.push_back(4'hF);
            end
        press_single(15);
        n0 = last_strobe_cyc;
        while (int'(cyc - n0) < 100) begin
            if (key_valid) got_offs.push_back(int'(cyc - n0));
            tick();
        end
        release_and_check(3);
        check("repeat_count", got_offs.size(), exp_offs.size());
        for (int i = 0; i < exp_offs.size() && i < got_offs.size(); i++)
            check("repeat_offset", got_offs[i], exp_offs[i]);

        repeat (10) tick();
        check("missing_strobes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
